// File: rtl/interleaver_scatter_pkg.sv
// interleaver_scatter shared types and width helpers.
// Build option: INTERLEAVER_SCATTER_SAT_EN selects saturating accumulation.
package interleaver_scatter_pkg;

  typedef enum logic {ACCUM, DRAIN} state_t;

  localparam int FO_D = 2;
  localparam int P_D  = 32;
  localparam int Z_D  = 8;
  localparam int W_D  = 16;

  localparam int ROW_W   = $clog2(P_D / Z_D);
  localparam int CYC_W   = $clog2(FO_D * P_D / Z_D);
  localparam int SWEEP_W = $clog2(FO_D);

  typedef logic signed [W_D-1:0] lane_t;

  function automatic int row_w(int p, int z);
    return $clog2(p / z);
  endfunction

  function automatic int cyc_w(int fo, int p, int z);
    return $clog2(fo * p / z);
  endfunction

endpackage

// File: rtl/interleaver_scatter_if.sv
// interleaver_scatter beat-in / drain-out bundle.
// Build option: INTERLEAVER_SCATTER_SAT_EN (no effect on this file).
interface interleaver_scatter_if
  import interleaver_scatter_pkg::*;
#(
  parameter int W  = 16,
  parameter int Z  = 8,
  parameter int RW = ROW_W,
  parameter int CW = CYC_W
);
  logic           in_valid;
  logic           in_ready;
  logic [W*Z-1:0] in_data;
  logic [CW-1:0]  cycle_index;
  logic           out_valid;
  logic           out_ready;
  logic [RW-1:0]  out_row;
  logic [W*Z-1:0] out_data;
  logic           out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, cycle_index,
    input  out_valid, out_row, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, cycle_index,
    output out_valid, out_row, out_data, out_last
  );
endinterface

// File: rtl/interleaver_scatter_row_calc.sv
// Per-lane bank row for a beat: start row of the sweep plus
// offset within the sweep, mod p/z. Build option: none.
module interleaver_row_calc
  import interleaver_scatter_pkg::*;
#(
  parameter int FO   = 2,
  parameter int P    = 32,
  parameter int Z    = 8,
  parameter int LANE = 0,
  parameter int RW   = row_w(P, Z),
  parameter int CW   = cyc_w(FO, P, Z),
  parameter logic [FO*Z*RW-1:0] SWEEPSTART = '0
) (
  input  logic [CW-1:0] i_cycle,
  output logic [RW-1:0] o_row
);
  logic [CW-1:0]      w_sweep;
  logic [RW-1:0]      w_k;
  logic [FO*Z*RW-1:0] w_sh;

  assign w_sweep = i_cycle >> RW;
  assign w_k     = i_cycle[RW-1:0];
  assign w_sh    = SWEEPSTART >> ((int'(w_sweep) * Z + LANE) * RW);
  assign o_row   = w_sh[RW-1:0] + w_k;
endmodule

// File: rtl/interleaver_scatter.sv
// Scatter/accumulate backprop lanes into interleaved neurons, then drain.
// Build option: INTERLEAVER_SCATTER_SAT_EN = saturating sweep>0 adds.
module interleaver_scatter
  import interleaver_scatter_pkg::*;
#(
  parameter int FO = 2,
  parameter int P  = 32,
  parameter int Z  = 8,
  parameter int W  = 16,
  parameter logic [FO*Z*row_w(P,Z)-1:0] SWEEPSTART = 32'h8772D82D
) (
  input logic clk,
  input logic reset,
  interleaver_scatter_if.slave bus
);
  localparam int RW   = row_w(P, Z);
  localparam int CW   = cyc_w(FO, P, Z);
  localparam int ROWS = P / Z;
  localparam int NCYC = FO * ROWS;

  state_t         r_state, w_state_n;
  logic [CW-1:0]  r_cycle, w_cycle_n;
  logic [RW-1:0]  r_row, w_row_n, w_rd_row;
  logic           r_valid, w_valid_n;
  logic           r_last, w_last_n;
  logic [W*Z-1:0] r_data, w_rd_data;
  logic           w_load, w_acc, w_first;

  logic signed [W-1:0] r_bank [Z][ROWS];
  logic [RW-1:0]       w_row [Z];
  logic signed [W-1:0] w_new [Z];

  assign w_acc   = bus.in_valid & bus.in_ready;
  assign w_first = (r_cycle >> RW) == '0;

  for (genvar l = 0; l < Z; l++) begin : g_lane
    logic signed [W-1:0] w_lane, w_old, w_add;

    interleaver_row_calc #(
      .FO(FO), .P(P), .Z(Z), .LANE(l),
      .SWEEPSTART(SWEEPSTART)
    ) u_rc (
      .i_cycle(r_cycle),
      .o_row  (w_row[l])
    );

    assign w_lane = bus.in_data[W*l +: W];
    assign w_old  = r_bank[l][w_row[l]];
`ifdef INTERLEAVER_SCATTER_SAT_EN
    logic signed [W:0] w_sum;
    assign w_sum = {w_old[W-1], w_old} + {w_lane[W-1], w_lane};
    assign w_add = (w_sum[W] != w_sum[W-1])
                 ? (w_sum[W] ? {1'b1, {(W-1){1'b0}}}
                             : {1'b0, {(W-1){1'b1}}})
                 : w_sum[W-1:0];
`else
    assign w_add = w_old + w_lane;
`endif
    assign w_new[l] = w_first ? w_lane : w_add;
    assign w_rd_data[W*l +: W] = r_bank[l][w_rd_row];
  end

  // Bank write: overwrite on sweep 0, accumulate afterwards.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int l = 0; l < Z; l++) begin
        r_bank[l][w_row[l]] <= w_new[l];
      end
    end
  end

  // Next-state: beat counting in ACCUM, row prefetch/advance in DRAIN.
  always_comb begin
    w_state_n = r_state;
    w_cycle_n = r_cycle;
    w_row_n   = r_row;
    w_valid_n = r_valid;
    w_last_n  = r_last;
    w_load    = 1'b0;
    w_rd_row  = r_row;
    unique case (r_state)
      ACCUM: begin
        if (w_acc) begin
          if (r_cycle == CW'(NCYC - 1)) begin
            w_cycle_n = '0;
            w_state_n = DRAIN;
          end else begin
            w_cycle_n = r_cycle + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!r_valid) begin
          w_load    = 1'b1;
          w_valid_n = 1'b1;
          w_last_n  = (r_row == RW'(ROWS - 1));
        end else if (bus.out_ready) begin
          if (r_last) begin
            w_valid_n = 1'b0;
            w_last_n  = 1'b0;
            w_row_n   = '0;
            w_state_n = ACCUM;
          end else begin
            w_rd_row = r_row + 1'b1;
            w_row_n  = w_rd_row;
            w_load   = 1'b1;
            w_last_n = (w_rd_row == RW'(ROWS - 1));
          end
        end
      end
      default: ;
    endcase
  end

  // Control and drain output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACCUM;
      r_cycle <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cycle <= w_cycle_n;
      r_row   <= w_row_n;
      r_valid <= w_valid_n;
      r_last  <= w_last_n;
      if (w_load) r_data <= w_rd_data;
    end
  end

  assign bus.in_ready    = (r_state == ACCUM);
  assign bus.cycle_index = r_cycle;
  assign bus.out_valid   = r_valid;
  assign bus.out_row     = r_row;
  assign bus.out_data    = r_data;
  assign bus.out_last    = r_last;
endmodule

// File: tb/tb_interleaver_scatter.sv
// Directed bench for interleaver_scatter (p=32 z=8 fo=2, W=16 and W=8).
// Honours INTERLEAVER_SCATTER_SAT_EN for the overflow expectation.
module tb_interleaver_scatter;
  localparam logic [31:0] SS = 32'h8772D82D;
`ifdef INTERLEAVER_SCATTER_SAT_EN
  localparam logic [7:0] E8 = 8'd127;
`else
  localparam logic [7:0] E8 = 8'hC8;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  interleaver_scatter_if #(.W(16), .Z(8), .RW(2), .CW(3)) bus ();
  interleaver_scatter_if #(.W(8), .Z(8), .RW(2), .CW(3)) bus8 ();

  interleaver_scatter #(
    .FO(2), .P(32), .Z(8), .W(16), .SWEEPSTART(SS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  interleaver_scatter #(
    .FO(2), .P(32), .Z(8), .W(8), .SWEEPSTART(SS)
  ) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  int n_tests = 0;
  int n_fail = 0;
  logic signed [15:0] mdl [32];
  logic signed [15:0] lane_v [8];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rowf(int c, int l);
    int s, k, st;
    s = c / 4;
    k = c % 4;
    st = int'((SS >> ((s * 8 + l) * 2)) & 32'd3);
    return (st + k) % 4;
  endfunction

  function automatic logic [127:0] expvec(int r);
    logic [127:0] v;
    for (int l = 0; l < 8; l++) v[l*16 +: 16] = mdl[r*8+l];
    return v;
  endfunction

  task automatic fill(logic signed [15:0] v);
    for (int i = 0; i < 32; i++) mdl[i] = v;
  endtask

  task automatic beat(int c, int gap);
    int n;
    int nr;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", 128'(bus.in_ready), 128'd1);
    chk("cycle_index", 128'(bus.cycle_index), 128'(c % 8));
    bus.in_valid = 1'b1;
    for (int l = 0; l < 8; l++) bus.in_data[l*16 +: 16] = lane_v[l];
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int l = 0; l < 8; l++) begin
      nr = rowf(c, l) * 8 + l;
      if (c < 4) mdl[nr] = lane_v[l];
      else mdl[nr] = mdl[nr] + lane_v[l];
    end
  endtask

  task automatic drain(int stall_row);
    int n;
    logic [127:0] d;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      n = 0;
      while (!bus.out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("out_valid", 128'(bus.out_valid), 128'd1);
      chk("out_row", 128'(bus.out_row), 128'(r));
      chk("out_data", bus.out_data, expvec(r));
      chk("out_last", 128'(bus.out_last), 128'(r == 3));
      chk("in_ready_drain", 128'(bus.in_ready), 128'd0);
      if (r == stall_row) begin
        bus.out_ready = 1'b0;
        d = bus.out_data;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", 128'(bus.out_valid), 128'd1);
          chk("stall_row", 128'(bus.out_row), 128'(r));
          chk("stall_data", bus.out_data, d);
        end
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("post_valid", 128'(bus.out_valid), 128'd0);
    chk("post_ready", 128'(bus.in_ready), 128'd1);
    chk("post_last", 128'(bus.out_last), 128'd0);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.in_data = '0;
    bus8.out_ready = 1'b1;
    fill(16'sd0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cycle", 128'(bus.cycle_index), 128'd0);
    chk("rst_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_data", bus.out_data, 128'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_row", 128'(bus.out_row), 128'd0);
    chk("rst_last", 128'(bus.out_last), 128'd0);

    // 1: all lanes 1, two sweeps -> every neuron 2
    for (int l = 0; l < 8; l++) lane_v[l] = 16'sd1;
    for (int c = 0; c < 8; c++) beat(c, 0);
    fill(16'sd2);
    drain(-1);

    // 2: single nonzero beat at c=0
    for (int c = 0; c < 8; c++) begin
      for (int l = 0; l < 8; l++) lane_v[l] = 16'sd0;
      if (c == 0) begin
        lane_v[0] = 16'sd5;
        lane_v[1] = -16'sd7;
      end
      beat(c, 0);
    end
    fill(16'sd0);
    mdl[8] = 16'sd5;
    mdl[25] = -16'sd7;
    drain(-1);

    // 3: lane value c*8+l
    for (int c = 0; c < 8; c++) begin
      for (int l = 0; l < 8; l++) lane_v[l] = 16'(c * 8 + l);
      beat(c, 0);
    end
    drain(-1);

    // 4: input gaps, signed values, backpressure on row 2
    for (int c = 0; c < 8; c++) begin
      for (int l = 0; l < 8; l++) lane_v[l] = 16'(c * 11 - l * 300);
      beat(c, (c * 5 + 1) % 3);
    end
    drain(2);

    // 5: reset mid-junction, then fresh junction of 3s
    for (int l = 0; l < 8; l++) lane_v[l] = 16'sd1;
    for (int c = 0; c < 5; c++) beat(c, 0);
    @(negedge clk);
    chk("pre_rst_cycle", 128'(bus.cycle_index), 128'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_cycle", 128'(bus.cycle_index), 128'd0);
    chk("mid_rst_ready", 128'(bus.in_ready), 128'd1);
    for (int l = 0; l < 8; l++) lane_v[l] = 16'sd3;
    for (int c = 0; c < 8; c++) beat(c, 0);
    fill(16'sd6);
    drain(-1);

    // 6: W=8, lane0 100 into neuron 8 on both sweeps
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n = 0;
      while (!bus8.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("w8_ready", 128'(bus8.in_ready), 128'd1);
      bus8.in_valid = 1'b1;
      bus8.in_data = (c == 0 || c == 7) ? 64'd100 : 64'd0;
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      n = 0;
      while (!bus8.out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("w8_valid", 128'(bus8.out_valid), 128'd1);
      chk("w8_row", 128'(bus8.out_row), 128'(r));
      chk("w8_data", 128'(bus8.out_data),
          (r == 1) ? 128'(E8) : 128'd0);
      @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
